// File: rtl/buscador_vizinhos_if.sv
// Signal bundle between the neighbour-fetch stage, its two memories and the
// path-search core. The stage uses the slave view; the environment uses master.
interface buscador_vizinhos_if #(
    parameter int ADDR_WIDTH          = 8,
    parameter int RELACOES_DATA_WIDTH = 8,
    parameter int VIZ_BITS            = 2
);
    logic                           req_valid_in;
    logic [ADDR_WIDTH-1:0]          req_no_in;
    logic                           req_ready_out;
    logic                           relacoes_rd_enable_out;
    logic [ADDR_WIDTH-1:0]          relacoes_rd_addr_out;
    logic [RELACOES_DATA_WIDTH-1:0] relacoes_rd_data_in;
    logic                           obstaculos_rd_enable_out;
    logic [ADDR_WIDTH-1:0]          obstaculos_rd_addr_out;
    logic                           obstaculos_rd_data_in;
    logic                           viz_valid_out;
    logic [ADDR_WIDTH-1:0]          viz_out;
    logic                           viz_ready_in;
    logic                           fim_out;
    logic [VIZ_BITS:0]              qtd_vizinhos_out;

    modport slave (
        input  req_valid_in, req_no_in, relacoes_rd_data_in,
               obstaculos_rd_data_in, viz_ready_in,
        output req_ready_out, relacoes_rd_enable_out, relacoes_rd_addr_out,
               obstaculos_rd_enable_out, obstaculos_rd_addr_out,
               viz_valid_out, viz_out, fim_out, qtd_vizinhos_out
    );

    modport master (
        output req_valid_in, req_no_in, relacoes_rd_data_in,
               obstaculos_rd_data_in, viz_ready_in,
        input  req_ready_out, relacoes_rd_enable_out, relacoes_rd_addr_out,
               obstaculos_rd_enable_out, obstaculos_rd_addr_out,
               viz_valid_out, viz_out, fim_out, qtd_vizinhos_out
    );
endinterface

// File: rtl/buscador_vizinhos.sv
// Neighbour fetch: reads a node's relation slots, drops empty or obstructed
// neighbours and streams the rest to the path-search core.
//
// state      | meaning
// IDLE       | waiting for a node request
// LE_REL     | relations read strobe for slot k
// ESPERA_REL | relations word arrives; sentinel check
// LE_OBS     | obstacle read strobe for the neighbour
// ESPERA_OBS | obstacle bit arrives
// SAIDA      | neighbour offered to consumer
// PROXIMO    | advance slot or finish
// FIM        | completion pulse with neighbour count
module buscador_vizinhos #(
    parameter int ADDR_WIDTH          = 8,
    parameter int RELACOES_DATA_WIDTH = 8,
    parameter int VIZ_BITS            = 2
) (
    input  logic              clk,
    input  logic              rst,
    buscador_vizinhos_if.slave bus
);
    localparam logic [VIZ_BITS-1:0] K_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, LE_REL, ESPERA_REL, LE_OBS, ESPERA_OBS, SAIDA, PROXIMO, FIM
    } estado_t;

    estado_t                        estado_q, estado_d;
    logic [ADDR_WIDTH-1:0]          no_q, no_d;
    logic [VIZ_BITS-1:0]            k_q, k_d;
    logic [VIZ_BITS:0]              cnt_q, cnt_d;
    logic [RELACOES_DATA_WIDTH-1:0] viz_q, viz_d;

    logic                           req_ready_q, req_ready_d;
    logic                           rel_en_q, rel_en_d;
    logic [ADDR_WIDTH-1:0]          rel_addr_q, rel_addr_d;
    logic                           obs_en_q, obs_en_d;
    logic [ADDR_WIDTH-1:0]          obs_addr_q, obs_addr_d;
    logic                           viz_valid_q, viz_valid_d;
    logic [ADDR_WIDTH-1:0]          viz_out_q, viz_out_d;
    logic                           fim_q, fim_d;
    logic [VIZ_BITS:0]              qtd_q, qtd_d;
    logic [ADDR_WIDTH+VIZ_BITS-1:0] rel_addr_full;

    always_comb begin
        estado_d = estado_q;
        no_d     = no_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        viz_d    = viz_q;

        case (estado_q)
            IDLE: begin
                if (bus.req_valid_in) begin
                    no_d     = bus.req_no_in;
                    k_d      = '0;
                    cnt_d    = '0;
                    estado_d = LE_REL;
                end
            end
            LE_REL:     estado_d = ESPERA_REL;
            ESPERA_REL: begin
                viz_d    = bus.relacoes_rd_data_in;
                estado_d = (&bus.relacoes_rd_data_in) ? PROXIMO : LE_OBS;
            end
            LE_OBS:     estado_d = ESPERA_OBS;
            ESPERA_OBS: estado_d = bus.obstaculos_rd_data_in ? PROXIMO : SAIDA;
            SAIDA: begin
                if (bus.viz_ready_in) begin
                    cnt_d    = cnt_q + (VIZ_BITS+1)'(1);
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                if (k_q == K_MAX) begin
                    estado_d = FIM;
                end else begin
                    k_d      = k_q + VIZ_BITS'(1);
                    estado_d = LE_REL;
                end
            end
            FIM:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        rel_addr_full = ({{VIZ_BITS{1'b0}}, no_d} << VIZ_BITS)
                      | {{ADDR_WIDTH{1'b0}}, k_d};
        req_ready_d   = (estado_d == IDLE);
        rel_en_d      = (estado_d == LE_REL);
        rel_addr_d    = rel_en_d ? rel_addr_full[ADDR_WIDTH-1:0] : '0;
        obs_en_d      = (estado_d == LE_OBS);
        obs_addr_d    = obs_en_d ? viz_d[ADDR_WIDTH-1:0] : '0;
        viz_valid_d   = (estado_d == SAIDA);
        viz_out_d     = viz_valid_d ? viz_d[ADDR_WIDTH-1:0] : '0;
        fim_d         = (estado_d == FIM);
        qtd_d         = fim_d ? cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= IDLE;
            no_q        <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            viz_q       <= '0;
            req_ready_q <= 1'b1;
            rel_en_q    <= 1'b0;
            rel_addr_q  <= '0;
            obs_en_q    <= 1'b0;
            obs_addr_q  <= '0;
            viz_valid_q <= 1'b0;
            viz_out_q   <= '0;
            fim_q       <= 1'b0;
            qtd_q       <= '0;
        end else begin
            estado_q    <= estado_d;
            no_q        <= no_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            viz_q       <= viz_d;
            req_ready_q <= req_ready_d;
            rel_en_q    <= rel_en_d;
            rel_addr_q  <= rel_addr_d;
            obs_en_q    <= obs_en_d;
            obs_addr_q  <= obs_addr_d;
            viz_valid_q <= viz_valid_d;
            viz_out_q   <= viz_out_d;
            fim_q       <= fim_d;
            qtd_q       <= qtd_d;
        end
    end

    assign bus.req_ready_out            = req_ready_q;
    assign bus.relacoes_rd_enable_out   = rel_en_q;
    assign bus.relacoes_rd_addr_out     = rel_addr_q;
    assign bus.obstaculos_rd_enable_out = obs_en_q;
    assign bus.obstaculos_rd_addr_out   = obs_addr_q;
    assign bus.viz_valid_out            = viz_valid_q;
    assign bus.viz_out                  = viz_out_q;
    assign bus.fim_out                  = fim_q;
    assign bus.qtd_vizinhos_out         = qtd_q;
endmodule
